// File: rtl/rca_share_arbiter.sv
// rca_share_arbiter: round-robin sequencer sharing one 32-bit ripple-carry
// adder among NREQ requesters; waits SETTLE cycles, returns tagged result.
module rca_share_arbiter #(
   parameter int NREQ   = 4,
   parameter int SETTLE = 2,
   parameter int IDW    = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req,
   input  logic [NREQ*32-1:0]  a_in,
   input  logic [NREQ*32-1:0]  b_in,
   input  logic [NREQ-1:0]     cin_in,
   output logic [NREQ-1:0]     gnt,
   output logic [31:0]         add_A,
   output logic [31:0]         add_B,
   output logic                add_Cin,
   input  logic [39:0]         add_Sum,
   input  logic                add_Cout,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [IDW-1:0]      res_id,
   output logic [31:0]         res_sum,
   output logic                res_cout,
   output logic                res_ovf,
   output logic                busy
);

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RESP} state_t;

   state_t          state_q, state_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [IDW-1:0]  win_q, win_d;
   logic [IDW-1:0]  id_q, id_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [31:0]     a_q, a_d;
   logic [31:0]     b_q, b_d;
   logic            cin_q, cin_d;
   logic            valid_q, valid_d;
   logic [31:0]     sum_q, sum_d;
   logic            cout_q, cout_d;
   logic            ovf_q, ovf_d;

   logic [IDW-1:0]  win, idx;
   logic            found;
   logic            take, capture, accept, busy_c;
   logic            unused_sum_hi;

   assign unused_sum_hi = ^add_Sum[39:32];

   // first set request at or above ptr, wrapping modulo NREQ
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = IDW'((int'(ptr_q) + k) % NREQ);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (found)         state_d = S_SETTLE;
         S_SETTLE: if (cnt_q == '0)   state_d = S_RESP;
         S_RESP:   if (res_ready)     state_d = S_IDLE;
         default:                     state_d = S_IDLE;
      endcase
   end

   always_comb begin
      take    = (state_q == S_IDLE) && found;
      capture = (state_q == S_SETTLE) && (cnt_q == '0);
      accept  = (state_q == S_RESP) && res_ready;
      busy_c  = (state_q != S_IDLE);
   end

   always_comb begin
      ptr_d   = ptr_q;
      win_d   = win_q;
      id_d    = id_q;
      cnt_d   = cnt_q;
      gnt_d   = '0;
      a_d     = a_q;
      b_d     = b_q;
      cin_d   = cin_q;
      valid_d = valid_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      if (take) begin
         gnt_d = NREQ'(1) << win;
         a_d   = a_in[32*win +: 32];
         b_d   = b_in[32*win +: 32];
         cin_d = cin_in[win];
         cnt_d = CW'(SETTLE - 1);
         win_d = win;
      end
      if ((state_q == S_SETTLE) && (cnt_q != '0))
         cnt_d = cnt_q - CW'(1);
      // overflow judged on the latched operands, not live inputs
      if (capture) begin
         sum_d   = add_Sum[31:0];
         cout_d  = add_Cout;
         ovf_d   = (a_q[31] == b_q[31]) && (add_Sum[31] != a_q[31]);
         id_d    = win_q;
         valid_d = 1'b1;
      end
      if (accept) begin
         valid_d = 1'b0;
         ptr_d   = (win_q == IDW'(NREQ - 1)) ? '0 : win_q + IDW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q   <= '0;
         win_q   <= '0;
         id_q    <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         cin_q   <= 1'b0;
         valid_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         id_q    <= id_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cin_q   <= cin_d;
         valid_q <= valid_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign gnt       = gnt_q;
   assign add_A     = a_q;
   assign add_B     = b_q;
   assign add_Cin   = cin_q;
   assign res_valid = valid_q;
   assign res_id    = id_q;
   assign res_sum   = sum_q;
   assign res_cout  = cout_q;
   assign res_ovf   = ovf_q;
   assign busy      = busy_c;

endmodule
